// File: rtl/z80_io_resp.sv
// Z80 I/O-port slave: synchronizes the bus strobes, decodes IORQ cycles in a 2**PORT_BITS window
// and turns them into register-file write strobes / read handshakes. Optional /WAIT drive: Z80IO_WAIT_EN.
module z80_io_resp #(
  parameter logic [7:0] PORT_BASE = 8'hC0,
  parameter int         PORT_BITS = 3,
  parameter int         RD_TMO    = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 z_iorq_n,
  input  logic                 z_mreq_n,
  input  logic                 z_m1_n,
  input  logic                 z_rd_n,
  input  logic                 z_wr_n,
  input  logic [15:0]          z_a,
  input  logic [7:0]           z_d_in,
  output logic [7:0]           z_d_out,
  output logic                 z_d_oe,
  output logic                 z_wait_n,
  output logic [PORT_BITS-1:0] reg_addr,
  output logic                 wr_stb,
  output logic [7:0]           wr_data,
  output logic                 rd_stb,
  input  logic [7:0]           rd_data,
  input  logic                 rd_vld,
  output logic                 rd_tmo
);
  localparam int CW = $clog2(RD_TMO + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_REL, ST_RDWAIT, ST_DRIVE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_armed;
  logic [4:0]    r_sync1;
  logic [4:0]    r_sync2;

  logic w_iorq_n, w_mreq_n, w_m1_n, w_rd_n, w_wr_n, w_sel;
  logic w_unused;

  // Synchronizers are left out of reset so they still track the pins while rst
  // is high; this lets the decoder see that a cycle was already in progress.
  always_ff @(posedge clk) begin
    r_sync1 <= {z_iorq_n, z_mreq_n, z_m1_n, z_rd_n, z_wr_n};
    r_sync2 <= r_sync1;
  end

  assign {w_iorq_n, w_mreq_n, w_m1_n, w_rd_n, w_wr_n} = r_sync2;
  assign w_sel = ~w_iorq_n & w_mreq_n & w_m1_n &
                 (z_a[7:PORT_BITS] == PORT_BASE[7:PORT_BITS]);
  assign w_unused = ^z_a[15:8];

`ifdef Z80IO_WAIT_EN
  logic r_wait_n;
  assign z_wait_n = r_wait_n;
`else
  assign z_wait_n = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_armed  <= 1'b0;
      z_d_out  <= 8'hFF;
      z_d_oe   <= 1'b0;
      reg_addr <= '0;
      wr_stb   <= 1'b0;
      wr_data  <= 8'h00;
      rd_stb   <= 1'b0;
      rd_tmo   <= 1'b0;
`ifdef Z80IO_WAIT_EN
      r_wait_n <= 1'b1;
`endif
    end else begin
      wr_stb <= 1'b0;
      rd_stb <= 1'b0;
      // A decode is only allowed after /IORQ has been seen idle, so each bus
      // cycle yields one strobe and a cycle straddling reset is skipped.
      if (w_iorq_n)
        r_armed <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (r_armed && w_sel && (!w_wr_n || !w_rd_n)) begin
            r_armed  <= 1'b0;
            reg_addr <= z_a[PORT_BITS-1:0];
            if (!w_wr_n) begin
              wr_data <= z_d_in;
              wr_stb  <= 1'b1;
              r_state <= ST_REL;
            end else begin
              rd_stb  <= 1'b1;
              r_cnt   <= '0;
              r_state <= ST_RDWAIT;
`ifdef Z80IO_WAIT_EN
              r_wait_n <= 1'b0;
`endif
            end
          end
        end
        ST_REL: begin
          if (w_iorq_n && w_wr_n)
            r_state <= ST_IDLE;
        end
        ST_RDWAIT: begin
          if (w_iorq_n || w_rd_n) begin
            r_state <= ST_IDLE;
`ifdef Z80IO_WAIT_EN
            r_wait_n <= 1'b1;
`endif
          end else if (rd_vld) begin
            z_d_out <= rd_data;
            z_d_oe  <= 1'b1;
            r_state <= ST_DRIVE;
`ifdef Z80IO_WAIT_EN
            r_wait_n <= 1'b1;
`endif
          end else if (r_cnt == CW'(RD_TMO - 1)) begin
            z_d_out <= 8'hFF;
            z_d_oe  <= 1'b1;
            rd_tmo  <= 1'b1;
            r_state <= ST_DRIVE;
`ifdef Z80IO_WAIT_EN
            r_wait_n <= 1'b1;
`endif
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_DRIVE: begin
          if (w_iorq_n || w_rd_n) begin
            z_d_oe  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_z80_io_resp.sv
// Directed bench for z80_io_resp: Z80 bus-cycle tasks, a register-file responder
// model and per-scenario tasks with hand-computed expectations.
module tb_z80_io_resp;
  logic        clk = 1'b0;
  logic        rst;
  logic        z_iorq_n, z_mreq_n, z_m1_n, z_rd_n, z_wr_n;
  logic [15:0] z_a;
  logic [7:0]  z_d_in;
  logic [7:0]  z_d_out;
  logic        z_d_oe, z_wait_n;
  logic [2:0]  reg_addr;
  logic        wr_stb, rd_stb, rd_vld, rd_tmo;
  logic [7:0]  wr_data, rd_data;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  logic [2:0] last_wa = 3'd0;
  logic [2:0] last_ra = 3'd0;
  logic [7:0] last_wd = 8'h00;
  logic [7:0] regf [8];
  logic [7:0] exp_mem [8];
  int resp_dly = 0;
  bit exp_wlo;

  z80_io_resp dut (
    .clk(clk), .rst(rst), .z_iorq_n(z_iorq_n), .z_mreq_n(z_mreq_n), .z_m1_n(z_m1_n),
    .z_rd_n(z_rd_n), .z_wr_n(z_wr_n), .z_a(z_a), .z_d_in(z_d_in), .z_d_out(z_d_out),
    .z_d_oe(z_d_oe), .z_wait_n(z_wait_n), .reg_addr(reg_addr), .wr_stb(wr_stb),
    .wr_data(wr_data), .rd_stb(rd_stb), .rd_data(rd_data), .rd_vld(rd_vld), .rd_tmo(rd_tmo)
  );

  always #5 clk = ~clk;

  // Strobe monitor; regf is the register file behind the DUT.
  always @(posedge clk) begin
    if (wr_stb) begin
      wr_cnt <= wr_cnt + 1;
      last_wa <= reg_addr;
      last_wd <= wr_data;
      regf[reg_addr] <= wr_data;
    end
    if (rd_stb) begin
      rd_cnt <= rd_cnt + 1;
      last_ra <= reg_addr;
    end
  end

  // Responder: answers rd_stb after resp_dly clks (0 = same cycle, <0 = never).
  initial begin
    rd_vld = 1'b0;
    rd_data = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (rd_stb && resp_dly >= 0) begin
        repeat (resp_dly) begin @(posedge clk); #1; end
        rd_data = regf[reg_addr];
        rd_vld = 1'b1;
        @(posedge clk); #1;
        rd_vld = 1'b0;
        rd_data = 8'h00;
      end
    end
  end

  task automatic release_bus;
    z_iorq_n = 1'b1; z_mreq_n = 1'b1; z_m1_n = 1'b1; z_rd_n = 1'b1; z_wr_n = 1'b1;
  endtask

  task automatic bus_cycle(input logic iorq, input logic mreq, input logic m1, input logic rd,
                           input logic wr, input logic [15:0] a, input logic [7:0] d,
                           input int hold, output bit saw_oe);
    saw_oe = 1'b0;
    @(negedge clk);
    z_a = a; z_d_in = d;
    z_iorq_n = iorq; z_mreq_n = mreq; z_m1_n = m1; z_rd_n = rd; z_wr_n = wr;
    repeat (hold) begin @(negedge clk); if (z_d_oe) saw_oe = 1'b1; end
    release_bus();
    repeat (4) begin @(negedge clk); if (z_d_oe) saw_oe = 1'b1; end
  endtask

  task automatic iord(input logic [15:0] a, input int dly, output logic [7:0] got,
                      output int fall, output bit ok, output bit wlo);
    resp_dly = dly;
    ok = 1'b0; wlo = 1'b0; fall = 99;
    @(negedge clk);
    z_a = a; z_iorq_n = 1'b0; z_rd_n = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!z_wait_n) wlo = 1'b1;
      if (z_d_oe) begin ok = 1'b1; break; end
    end
    got = z_d_out;
    @(negedge clk);
    release_bus();
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (!z_d_oe) begin fall = i; break; end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    release_bus();
    z_a = 16'h0000; z_d_in = 8'h00;
    repeat (4) @(negedge clk);
    n_cmp++; if (z_d_out !== 8'hFF) begin n_err++; $display("FAIL reset_d_out got %h want ff", z_d_out); end
    n_cmp++; if (z_d_oe !== 1'b0) begin n_err++; $display("FAIL reset_oe got %b want 0", z_d_oe); end
    n_cmp++; if (z_wait_n !== 1'b1) begin n_err++; $display("FAIL reset_wait got %b want 1", z_wait_n); end
    n_cmp++; if ({reg_addr, wr_stb, rd_stb, rd_tmo} !== 6'd0) begin n_err++; $display("FAIL reset_ctl got %b want 0", {reg_addr, wr_stb, rd_stb, rd_tmo}); end
    n_cmp++; if (wr_data !== 8'h00) begin n_err++; $display("FAIL reset_wr_data got %h want 00", wr_data); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write;
    int n0, r0; bit oe;
    n0 = wr_cnt;
    bus_cycle(0, 1, 1, 1, 0, 16'h00C3, 8'h5A, 10, oe);
    exp_mem[3] = 8'h5A;
    n_cmp++; if (wr_cnt !== n0 + 1) begin n_err++; $display("FAIL wr_count got %0d want %0d", wr_cnt, n0 + 1); end
    n_cmp++; if (last_wa !== 3'd3) begin n_err++; $display("FAIL wr_addr got %0d want 3", last_wa); end
    n_cmp++; if (last_wd !== 8'h5A) begin n_err++; $display("FAIL wr_data got %h want 5a", last_wd); end
    n_cmp++; if (oe !== 1'b0) begin n_err++; $display("FAIL wr_oe got %b want 0", oe); end
    n0 = wr_cnt; r0 = rd_cnt;
    bus_cycle(0, 1, 1, 0, 0, 16'h00C5, 8'hA7, 5, oe);
    exp_mem[5] = 8'hA7;
    n_cmp++; if (wr_cnt !== n0 + 1 || rd_cnt !== r0) begin n_err++; $display("FAIL rdwr_low counts got wr %0d rd %0d want %0d %0d", wr_cnt, rd_cnt, n0 + 1, r0); end
    n_cmp++; if ({last_wa, last_wd} !== {3'd5, 8'hA7}) begin n_err++; $display("FAIL rdwr_low got %0d/%h want 5/a7", last_wa, last_wd); end
    $display("test_write done");
  endtask

  task automatic test_read;
    logic [7:0] got; int fall, r0; bit ok, wlo;
    r0 = rd_cnt;
    iord(16'h12C5, 2, got, fall, ok, wlo);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL rd_oe_timeout got no oe want oe"); end
    n_cmp++; if (got !== 8'hA7) begin n_err++; $display("FAIL rd_data got %h want a7", got); end
    n_cmp++; if (fall > 3) begin n_err++; $display("FAIL rd_oe_fall got %0d clk want <=3", fall); end
    n_cmp++; if (rd_cnt !== r0 + 1 || last_ra !== 3'd5) begin n_err++; $display("FAIL rd_stb got %0d/%0d want %0d/5", rd_cnt, last_ra, r0 + 1); end
    n_cmp++; if (wlo !== exp_wlo) begin n_err++; $display("FAIL rd_wait_low got %b want %b", wlo, exp_wlo); end
    $display("test_read done data=%h", got);
  endtask

  task automatic test_nomatch;
    int n0, r0; bit oe, any_oe;
    n0 = wr_cnt; r0 = rd_cnt; any_oe = 1'b0;
    bus_cycle(0, 1, 1, 1, 0, 16'h00B3, 8'h11, 6, oe); any_oe |= oe;
    bus_cycle(0, 1, 1, 0, 1, 16'h00B3, 8'h00, 6, oe); any_oe |= oe;
    bus_cycle(1, 0, 1, 1, 0, 16'h00C0, 8'h22, 6, oe); any_oe |= oe;
    bus_cycle(1, 0, 0, 0, 1, 16'h00C0, 8'h00, 6, oe); any_oe |= oe;
    bus_cycle(0, 1, 0, 1, 1, 16'h00C0, 8'h00, 6, oe); any_oe |= oe;
    n_cmp++; if (wr_cnt !== n0 || rd_cnt !== r0) begin n_err++; $display("FAIL nomatch_stb got wr %0d rd %0d want %0d %0d", wr_cnt, rd_cnt, n0, r0); end
    n_cmp++; if (any_oe !== 1'b0) begin n_err++; $display("FAIL nomatch_oe got 1 want 0"); end
    $display("test_nomatch done");
  endtask

  task automatic test_abort;
    int r0; bit oe;
    r0 = rd_cnt;
    resp_dly = 5;
    bus_cycle(0, 1, 1, 0, 1, 16'h00C4, 8'h00, 4, oe);
    repeat (6) @(negedge clk);
    n_cmp++; if (rd_cnt !== r0 + 1) begin n_err++; $display("FAIL abort_stb got %0d want %0d", rd_cnt, r0 + 1); end
    n_cmp++; if (oe !== 1'b0 || z_d_oe !== 1'b0) begin n_err++; $display("FAIL abort_oe got %b want 0", oe | z_d_oe); end
    n_cmp++; if (rd_tmo !== 1'b0) begin n_err++; $display("FAIL abort_tmo got %b want 0", rd_tmo); end
    $display("test_abort done");
  endtask

  task automatic test_timeout;
    logic [7:0] got; int fall; bit ok, wlo;
    iord(16'h00C1, -1, got, fall, ok, wlo);
    n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL tmo_oe got no oe want oe"); end
    n_cmp++; if (got !== 8'hFF) begin n_err++; $display("FAIL tmo_data got %h want ff", got); end
    n_cmp++; if (rd_tmo !== 1'b1) begin n_err++; $display("FAIL tmo_flag got %b want 1", rd_tmo); end
    n_cmp++; if (fall > 3) begin n_err++; $display("FAIL tmo_oe_fall got %0d want <=3", fall); end
    $display("test_timeout done data=%h", got);
  endtask

  task automatic test_random;
    int n0, r0, fall, dly, nops;
    logic [2:0] p; logic [7:0] d, got; bit oe, ok, wlo;
    logic [15:0] a;
    nops = 0;
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        n0 = wr_cnt; r0 = rd_cnt;
        a = {8'($urandom), 5'b11000, 3'($urandom)};
        case ($urandom_range(0, 2))
          0: bus_cycle(1, 0, 1, 0, 1, a, 8'h00, 5, oe);
          1: bus_cycle(1, 0, 1, 1, 0, a, 8'($urandom), 5, oe);
          default: bus_cycle(1, 0, 0, 0, 1, a, 8'h00, 5, oe);
        endcase
        n_cmp++; if (wr_cnt !== n0 || rd_cnt !== r0 || oe !== 1'b0) begin n_err++; $display("FAIL noise_%0d wr %0d rd %0d oe %b want %0d %0d 0", i, wr_cnt, rd_cnt, oe, n0, r0); end
      end
      p = (i < 8) ? 3'(i) : 3'($urandom);
      a = {8'($urandom), 5'b11000, p};
      if (i < 8 || $urandom_range(0, 1) == 1) begin
        d = 8'($urandom);
        n0 = wr_cnt;
        bus_cycle(0, 1, 1, 1, 0, a, d, $urandom_range(4, 8), oe);
        exp_mem[p] = d;
        n_cmp++; if (wr_cnt !== n0 + 1 || {last_wa, last_wd} !== {p, d}) begin n_err++; $display("FAIL rnd_wr_%0d cnt %0d a %0d d %h want %0d %0d %h", i, wr_cnt, last_wa, last_wd, n0 + 1, p, d); end
      end else begin
        r0 = rd_cnt;
`ifdef Z80IO_WAIT_EN
        dly = 5;
`else
        dly = $urandom_range(0, 4);
`endif
        iord(a, dly, got, fall, ok, wlo);
        n_cmp++; if (!ok || got !== exp_mem[p] || rd_cnt !== r0 + 1) begin n_err++; $display("FAIL rnd_rd_%0d port %0d got %h want %h (ok %b cnt %0d)", i, p, got, exp_mem[p], ok, rd_cnt); end
      end
      nops++;
    end
    $display("test_random done ops=%0d", nops);
  endtask

  task automatic test_reset_mid;
    int n0; bit oe;
    n0 = wr_cnt;
    @(negedge clk);
    z_a = 16'h00C2; z_d_in = 8'h33; z_iorq_n = 1'b0; z_wr_n = 1'b0;
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_cmp++; if ({z_d_oe, rd_tmo, reg_addr} !== 5'd0 || z_d_out !== 8'hFF || wr_data !== 8'h00) begin n_err++; $display("FAIL midrst_outputs got oe %b tmo %b a %0d d %h wd %h", z_d_oe, rd_tmo, reg_addr, z_d_out, wr_data); end
    repeat (6) @(negedge clk);
    release_bus();
    repeat (4) @(negedge clk);
    n_cmp++; if (wr_cnt !== n0) begin n_err++; $display("FAIL midrst_no_stb got %0d want %0d", wr_cnt, n0); end
    n0 = wr_cnt;
    bus_cycle(0, 1, 1, 1, 0, 16'h00C6, 8'h3C, 5, oe);
    n_cmp++; if (wr_cnt !== n0 + 1 || {last_wa, last_wd} !== {3'd6, 8'h3C}) begin n_err++; $display("FAIL midrst_next got %0d/%0d/%h want %0d/6/3c", wr_cnt, last_wa, last_wd, n0 + 1); end
    $display("test_reset_mid done");
  endtask

  initial begin
`ifdef Z80IO_WAIT_EN
    exp_wlo = 1'b1;
`else
    exp_wlo = 1'b0;
`endif
    test_reset();
    test_write();
    test_read();
    test_nomatch();
    test_abort();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end
endmodule
